// File: rtl/approx_eval_pkg.sv
// ============================================================================
// Module      : approx_eval_pkg
// Description : Shared state encoding and constants for the approximate-circuit
//               error monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package approx_eval_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned DRAIN_CYCLES = 2;

endpackage

`default_nettype wire

// File: rtl/approx_err_stage.sv
// ============================================================================
// Module      : approx_err_stage
// Description : Second pipeline stage. Computes the absolute difference of the
//               two output words, compares it with the threshold latched at
//               start, and accumulates max error, violation count and the
//               first violating vector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module approx_err_stage
  import approx_eval_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [N_OUT-1:0] et,
  input  logic             s1_vld,
  input  logic [N_IN-1:0]  s1_vec,
  input  logic [N_OUT-1:0] s1_exact,
  input  logic [N_OUT-1:0] s1_approx,
  output logic [N_OUT-1:0] max_err,
  output logic [N_IN:0]    viol_cnt,
  output logic             first_viol_vld,
  output logic [N_IN-1:0]  first_viol_vec
);

  localparam logic [N_IN:0] c_viol_max = {1'b1, {N_IN{1'b0}}};

  logic [N_OUT-1:0] r_et;
  logic [N_OUT-1:0] r_max_err;
  logic [N_IN:0]    r_viol_cnt;
  logic             r_first_vld;
  logic [N_IN-1:0]  r_first_vec;

  logic [N_OUT-1:0] w_err;
  logic             w_flag;

  // Subtract the smaller from the larger so the result never wraps.
  assign w_err  = (s1_exact >= s1_approx) ? (s1_exact - s1_approx)
                                          : (s1_approx - s1_exact);
  assign w_flag = (w_err > r_et);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_et        <= '0;
      r_max_err   <= '0;
      r_viol_cnt  <= '0;
      r_first_vld <= 1'b0;
      r_first_vec <= '0;
    end else if (clr) begin
      r_et        <= et;
      r_max_err   <= '0;
      r_viol_cnt  <= '0;
      r_first_vld <= 1'b0;
      r_first_vec <= '0;
    end else if (s1_vld) begin
      if (w_err > r_max_err) begin
        r_max_err <= w_err;
      end
      if (w_flag && (r_viol_cnt != c_viol_max)) begin
        r_viol_cnt <= r_viol_cnt + 1'b1;
      end
      if (w_flag && !r_first_vld) begin
        r_first_vld <= 1'b1;
        r_first_vec <= s1_vec;
      end
    end
  end

  assign max_err        = r_max_err;
  assign viol_cnt       = r_viol_cnt;
  assign first_viol_vld = r_first_vld;
  assign first_viol_vec = r_first_vec;

endmodule

`default_nettype wire

// File: rtl/approx_error_monitor.sv
// ============================================================================
// Module      : approx_error_monitor
// Description : Exhaustive sweep of all input vectors into an exact and an
//               approximate circuit, with error statistics and pass verdict.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module approx_error_monitor
  import approx_eval_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_OUT-1:0] et,
  output logic [N_IN-1:0]  vec_out,
  input  logic [N_OUT-1:0] exact_in,
  input  logic [N_OUT-1:0] approx_in,
  output logic             busy,
  output logic             done,
  output logic [N_OUT-1:0] max_err,
  output logic [N_IN:0]    viol_cnt,
  output logic             first_viol_vld,
  output logic [N_IN-1:0]  first_viol_vec,
  output logic             pass
);

  localparam logic [N_IN:0] c_last_vec = {1'b0, {N_IN{1'b1}}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N_IN:0]    r_cnt;
  logic [1:0]       r_drain;
  logic             r_pass;
  logic             r_s1_vld;
  logic [N_IN-1:0]  r_s1_vec;
  logic [N_OUT-1:0] r_s1_exact;
  logic [N_OUT-1:0] r_s1_approx;

  logic w_start_acc;
  logic w_last_vec;
  logic w_drain_end;

  assign w_start_acc = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last_vec  = (r_cnt == c_last_vec);
  assign w_drain_end = (r_drain == 2'(DRAIN_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start_acc) w_state_nxt = SWEEP;
      SWEEP:   if (w_last_vec)  w_state_nxt = DRAIN;
      DRAIN:   if (w_drain_end) w_state_nxt = DONE;
      DONE:    if (w_start_acc) w_state_nxt = SWEEP;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      SWEEP:   busy = 1'b1;
      DRAIN:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Counter parks on the terminal vector so vec_out holds through DRAIN/DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_drain <= '0;
      r_pass  <= 1'b0;
    end else begin
      if (w_start_acc) begin
        r_cnt <= '0;
      end else if ((r_state == SWEEP) && !w_last_vec) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (r_state == DRAIN) begin
        r_drain <= r_drain + 1'b1;
      end else begin
        r_drain <= '0;
      end

      if (w_start_acc) begin
        r_pass <= 1'b0;
      end else if ((r_state == DRAIN) && w_drain_end) begin
        r_pass <= (viol_cnt == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld    <= 1'b0;
      r_s1_vec    <= '0;
      r_s1_exact  <= '0;
      r_s1_approx <= '0;
    end else begin
      r_s1_vld    <= (r_state == SWEEP);
      r_s1_vec    <= r_cnt[N_IN-1:0];
      r_s1_exact  <= exact_in;
      r_s1_approx <= approx_in;
    end
  end

  approx_err_stage #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT)
  ) u_err_stage (
    .clk            (clk),
    .rst            (rst),
    .clr            (w_start_acc),
    .et             (et),
    .s1_vld         (r_s1_vld),
    .s1_vec         (r_s1_vec),
    .s1_exact       (r_s1_exact),
    .s1_approx      (r_s1_approx),
    .max_err        (max_err),
    .viol_cnt       (viol_cnt),
    .first_viol_vld (first_viol_vld),
    .first_viol_vec (first_viol_vec)
  );

  assign vec_out = r_cnt[N_IN-1:0];
  assign pass    = r_pass;

endmodule

`default_nettype wire

// File: tb/tb_approx_error_monitor.sv
// ============================================================================
// Module      : tb_approx_error_monitor
// Description : Scoreboard bench for approx_error_monitor with a 2-bit adder
//               as the exact circuit and selectable approximate behaviours.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_approx_error_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] et = 3'd0;
  logic [3:0] vec_out;
  logic [2:0] exact_in;
  logic [2:0] approx_in;
  logic       busy;
  logic       done;
  logic [2:0] max_err;
  logic [4:0] viol_cnt;
  logic       first_viol_vld;
  logic [3:0] first_viol_vec;
  logic       pass;

  int mode = 0;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  logic prev_done = 1'b0;

  typedef struct {
    int max_err;
    int viol;
    int fvld;
    int fvec;
    int pass;
    int done_cyc;
  } exp_t;

  exp_t exp_q[$];

  approx_error_monitor #(.N_IN(4), .N_OUT(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .et             (et),
    .vec_out        (vec_out),
    .exact_in       (exact_in),
    .approx_in      (approx_in),
    .busy           (busy),
    .done           (done),
    .max_err        (max_err),
    .viol_cnt       (viol_cnt),
    .first_viol_vld (first_viol_vld),
    .first_viol_vec (first_viol_vec),
    .pass           (pass)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Circuits under evaluation: exact is a 2-bit adder, approx chosen by mode.
  always_comb begin
    exact_in  = {1'b0, vec_out[1:0]} + {1'b0, vec_out[3:2]};
    approx_in = exact_in;
    if (mode == 1) approx_in = 3'b011;
    else if (mode == 2 && vec_out == 4'b1111) approx_in = exact_in ^ 3'b100;
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per rising edge of done.
  always @(negedge clk) begin
    if (done && !prev_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_cycle", cyc, e.done_cyc);
        check("max_err", int'(max_err), e.max_err);
        check("viol_cnt", int'(viol_cnt), e.viol);
        check("first_viol_vld", int'(first_viol_vld), e.fvld);
        check("first_viol_vec", int'(first_viol_vec), e.fvec);
        check("pass", int'(pass), e.pass);
        check("vec_out_hold", int'(vec_out), 15);
      end
    end
    prev_done = done;
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_vec_out"}, int'(vec_out), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_max_err"}, int'(max_err), 0);
    check({tag, "_viol_cnt"}, int'(viol_cnt), 0);
    check({tag, "_fvld"}, int'(first_viol_vld), 0);
    check({tag, "_fvec"}, int'(first_viol_vec), 0);
    check({tag, "_pass"}, int'(pass), 0);
  endtask

  // Issue start, optionally disturb (start pulse + et change) at cycle t+dist_at.
  task automatic run_sweep(input int m, input int th, input int dist_at,
                           input int x_max, input int x_viol, input int x_fvld,
                           input int x_fvec, input int x_pass);
    exp_t e;
    int t_edge;
    bit seen;
    @(negedge clk);
    mode  = m;
    et    = 3'(th);
    start = 1'b1;
    t_edge = cyc + 1;
    e = '{x_max, x_viol, x_fvld, x_fvec, x_pass, t_edge + 18};
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    check("start_vec_out", int'(vec_out), 0);
    check("start_busy", int'(busy), 1);
    check("start_done", int'(done), 0);
    check("start_cleared", int'({max_err, viol_cnt, first_viol_vld, pass}), 0);
    if (dist_at > 1) begin
      repeat (dist_at - 1) @(negedge clk);
      start = 1'b1;
      et    = ~et;
      @(negedge clk);
      start = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) check("done_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("reset");

    run_sweep(0, 0, 0, 0, 0, 0, 0, 1);   // approx == exact
    run_sweep(1, 3, 0, 3, 0, 0, 0, 1);   // constant 3, et=3
    run_sweep(1, 2, 0, 3, 2, 1, 0, 0);   // constant 3, et=2
    run_sweep(2, 3, 0, 4, 1, 1, 15, 0);  // single flip on 1111

    // Reset mid-sweep at cycle t+8 discards everything.
    @(negedge clk);
    mode  = 1;
    et    = 3'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_rst_fvld", int'(first_viol_vld), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_values("mid_rst");
    run_sweep(0, 0, 0, 0, 0, 0, 0, 1);

    // Start pulse and et change at t+5 are ignored; then restart from DONE.
    run_sweep(1, 2, 5, 3, 2, 1, 0, 0);
    run_sweep(0, 0, 0, 0, 0, 0, 0, 1);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
